eeprom_wr_seq: RTL and testbench

EEPROM_WR_SEQ -- requirements
Module: eeprom_wr_seq

---
 rtl/eeprom_wr_seq_pkg.sv | 33 +++
 rtl/eeprom_wr_seq_fifo.sv | 73 +++++++
 rtl/eeprom_wr_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_eeprom_wr_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_wr_seq_pkg.sv
// Shared types for the EEPROM write sequencer: i2c engine command and status
// codes, FSM state encoding and a pointer helper.
package enum_t;

    typedef enum logic [1:0] {
        EN_NONE = 2'd0,
        EN_WR   = 2'd1,
        EN_STOP = 2'd2
    } en_t;

    typedef enum logic [1:0] {
        WR   = 2'd0,
        ACK  = 2'd1,
        NACK = 2'd2,
        STOP = 2'd3
    } i2c_t;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_LOAD = 3'd1;
    localparam state_t S_DEV  = 3'd2;
    localparam state_t S_PTR  = 3'd3;
    localparam state_t S_DATA = 3'd4;
    localparam state_t S_STOP = 3'd5;
    localparam state_t S_DONE = 3'd6;

    // EEPROM word pointer advances modulo 256
    function automatic logic [7:0] ptr_inc(input logic [7:0] p);
        return p + 8'd1;
    endfunction

endpackage

// File: rtl/eeprom_wr_seq_fifo.sv
// seq_fifo: synchronous byte FIFO holding one host burst. Exposes the head
// byte and the byte behind it so the sequencer can present the next byte in
// the cycle following a pop.
module seq_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic [7:0]               rdata_nxt,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_ptr_inc_s;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign push_ok_s    = push && (count_r != FULL_C);
    assign pop_ok_s     = pop && (count_r != {CW{1'b0}});
    assign rd_ptr_inc_s = rd_ptr_r + AW'(1);
    assign rdata        = mem_r[rd_ptr_r];
    assign rdata_nxt    = mem_r[rd_ptr_inc_s];
    assign full         = (count_r == FULL_C);
    assign empty        = (count_r == {CW{1'b0}});
    assign count        = count_r;

    // Read/write pointers and occupancy; flush empties the buffer at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates reads
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/eeprom_wr_seq.sv
// eeprom_wr_seq: buffers a host burst and drives an i2c byte engine through
// device address, word pointer, data and stop phases.
// Build option SEQ_WRITE_EN: one i2c transaction per burst (page write).
// Default build: one transaction per byte with the pointer advancing each time.
module eeprom_wr_seq
    import enum_t::*;
#(
    parameter logic [7:0] DEV_ADDR = 8'hA0,
    parameter int         DEPTH    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    input  logic       cmd_last,
    output logic [7:0] data,
    output en_t        en,
    input  i2c_t       st,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [7:0]    ptr_r;
    logic [7:0]    ptr_nxt_s;
    logic          err_nxt_s;
    logic          push_s;
    logic          pop_s;
    logic          flush_s;
    logic [7:0]    head_s;
    logic [7:0]    head_nxt_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] count_nxt_s;
    logic [7:0]    data_nxt_s;
    en_t           en_nxt_s;
    logic          ready_nxt_s;
    logic          busy_nxt_s;
    logic          done_nxt_s;

    assign push_s = cmd_valid && cmd_ready && !full_s;

    seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_s),
        .push      (push_s),
        .wdata     (cmd_data),
        .pop       (pop_s),
        .rdata     (head_s),
        .rdata_nxt (head_nxt_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // Sequencer transitions, pointer update, error capture and buffer pops
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        err_nxt_s   = err;
        pop_s       = 1'b0;
        flush_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (push_s) begin
                    ptr_nxt_s   = cmd_addr;
                    err_nxt_s   = 1'b0;
                    state_nxt_s = cmd_last ? S_DEV : S_LOAD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (push_s && (cmd_last || (count_s == (FULL_C - ONE_C)))) begin
                    state_nxt_s = S_DEV;
                end else begin
                    state_nxt_s = S_LOAD;
                end
            end
            S_DEV: begin
                if (st == ACK) begin
                    state_nxt_s = S_PTR;
                end else if (st == NACK) begin
                    err_nxt_s   = 1'b1;
                    flush_s     = 1'b1;
                    state_nxt_s = S_STOP;
                end else begin
                    state_nxt_s = S_DEV;
                end
            end
            S_PTR: begin
                if (st == ACK) begin
                    state_nxt_s = S_DATA;
                end else if (st == NACK) begin
                    err_nxt_s   = 1'b1;
                    flush_s     = 1'b1;
                    state_nxt_s = S_STOP;
                end else begin
                    state_nxt_s = S_PTR;
                end
            end
            S_DATA: begin
                if ((st == ACK) && !empty_s) begin
                    pop_s = 1'b1;
`ifdef SEQ_WRITE_EN
                    if (count_s == ONE_C) begin
                        state_nxt_s = S_STOP;
                    end else begin
                        state_nxt_s = S_DATA;
                    end
`else
                    ptr_nxt_s   = ptr_inc(ptr_r);
                    state_nxt_s = S_STOP;
`endif
                end else if (st == NACK) begin
                    err_nxt_s   = 1'b1;
                    flush_s     = 1'b1;
                    state_nxt_s = S_STOP;
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            S_STOP: begin
                if (st == STOP) begin
                    if (err) begin
                        state_nxt_s = S_IDLE;
                    end else if (!empty_s) begin
                        state_nxt_s = S_DEV;
                    end else begin
                        state_nxt_s = S_DONE;
                    end
                end else begin
                    state_nxt_s = S_STOP;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Buffer occupancy after this cycle's push/pop/flush, for the ready flag
    always_comb begin
        count_nxt_s = count_s;
        if (flush_s) begin
            count_nxt_s = {CW{1'b0}};
        end else if (push_s && !pop_s) begin
            count_nxt_s = count_s + ONE_C;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_s - ONE_C;
        end else begin
            count_nxt_s = count_s;
        end
    end

    // Output values for the state being entered, so registered outputs line up
    always_comb begin
        data_nxt_s  = 8'h00;
        en_nxt_s    = EN_NONE;
        case (state_nxt_s)
            S_DEV: begin
                data_nxt_s = DEV_ADDR & 8'hFE;
                en_nxt_s   = EN_WR;
            end
            S_PTR: begin
                data_nxt_s = ptr_nxt_s;
                en_nxt_s   = EN_WR;
            end
            S_DATA: begin
                data_nxt_s = pop_s ? head_nxt_s : head_s;
                en_nxt_s   = EN_WR;
            end
            S_STOP: begin
                data_nxt_s = 8'h00;
                en_nxt_s   = EN_STOP;
            end
            default: begin
                data_nxt_s = 8'h00;
                en_nxt_s   = EN_NONE;
            end
        endcase
        ready_nxt_s = ((state_nxt_s == S_IDLE) || (state_nxt_s == S_LOAD)) &&
                      (count_nxt_s != FULL_C);
        busy_nxt_s  = (state_nxt_s != S_IDLE) && (state_nxt_s != S_LOAD);
        done_nxt_s  = (state_nxt_s == S_DONE);
    end

    // State, pointer and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            ptr_r     <= 8'h00;
            data      <= 8'h00;
            en        <= EN_NONE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            data      <= data_nxt_s;
            en        <= en_nxt_s;
            cmd_ready <= ready_nxt_s;
            busy      <= busy_nxt_s;
            done      <= done_nxt_s;
            err       <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_eeprom_wr_seq.sv
// Self-checking bench for eeprom_wr_seq: random bursts against a reference
// model of the expected i2c byte stream, plus reset and NACK scenarios.
module tb_eeprom_wr_seq;
    import enum_t::*;

    localparam int         DEPTH   = 16;
    localparam int         STOP_MK = 256;
    localparam logic [7:0] DEV_P   = 8'hA1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_last = 1'b0;
    logic [7:0] data;
    en_t        en;
    i2c_t       st = WR;
    logic       busy;
    logic       done;
    logic       err;

    int         checks = 0;
    int         errors = 0;
    int         cap_q[$];
    int         exp_q[$];
    logic [7:0] bytes_a [DEPTH];
    int         wr_idx = 0;
    int         nack_at = -1;
    int         done_cnt = 0;
    bit         pulse = 1'b0;

    eeprom_wr_seq #(.DEV_ADDR(DEV_P), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_last  (cmd_last),
        .data      (data),
        .en        (en),
        .st        (st),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // i2c engine model: random latency, one-cycle status pulses, logs bytes
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (!rst_n) begin
                st = WR;
                pulse = 1'b0;
            end else if (pulse) begin
                st = WR;
                pulse = 1'b0;
            end else if (en == EN_WR && $urandom_range(0, 2) == 0) begin
                cap_q.push_back(int'(data));
                st = (wr_idx == nack_at) ? NACK : ACK;
                wr_idx++;
                pulse = 1'b1;
            end else if (en == EN_STOP && $urandom_range(0, 2) == 0) begin
                cap_q.push_back(STOP_MK);
                st = STOP;
                pulse = 1'b1;
            end else begin
                st = WR;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int writes_for(input int n);
`ifdef SEQ_WRITE_EN
        return n + 2;
`else
        return 3 * n;
`endif
    endfunction

    // Reference: expected engine stream from the burst, truncated at a NACK
    task automatic build_exp(input logic [7:0] addr, input int n, input int nack_k);
        int full_q[$];
        int w;
        int dev_b;
        dev_b = int'(DEV_P & 8'hFE);
`ifdef SEQ_WRITE_EN
        full_q.push_back(dev_b);
        full_q.push_back(int'(addr));
        for (int i = 0; i < n; i++) full_q.push_back(int'(bytes_a[i]));
        full_q.push_back(STOP_MK);
`else
        for (int i = 0; i < n; i++) begin
            full_q.push_back(dev_b);
            full_q.push_back((int'(addr) + i) % 256);
            full_q.push_back(int'(bytes_a[i]));
            full_q.push_back(STOP_MK);
        end
`endif
        exp_q.delete();
        w = 0;
        for (int j = 0; j < full_q.size(); j++) begin
            exp_q.push_back(full_q[j]);
            if (nack_k >= 0 && full_q[j] != STOP_MK) begin
                if (w == nack_k) begin
                    exp_q.push_back(STOP_MK);
                    break;
                end
                w++;
            end
        end
    endtask

    task automatic send_burst(input logic [7:0] addr, input int n, input int base, input int nack_k);
        int t;
        for (int i = 0; i < n; i++) bytes_a[i] = (base < 0) ? 8'($urandom) : 8'(base + i);
        build_exp(addr, n, nack_k);
        cap_q.delete();
        nack_at = (nack_k < 0) ? -1 : wr_idx + nack_k;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_addr  = (i == 0) ? addr : 8'($urandom);
            cmd_data  = bytes_a[i];
            cmd_last  = (i == n - 1);
            t = 0;
            while (!cmd_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) check("ready_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            cmd_last  = 1'b0;
        end
        check("ready_after_last", cmd_ready, 1'b0);
        check("busy_after_last", busy, 1'b1);
    endtask

    task automatic finish_burst(input int nack_k);
        int t;
        int d0;
        int lim;
        d0 = done_cnt;
        t = 0;
        while (busy && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("busy_timeout", (t < 4000), 1'b1);
        #2;
        check("stream_len", cap_q.size(), exp_q.size());
        lim = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) check($sformatf("stream[%0d]", i), cap_q[i], exp_q[i]);
        check("done_pulses", done_cnt - d0, (nack_k < 0) ? 1 : 0);
        check("err_flag", err, (nack_k >= 0));
        check("ready_idle", cmd_ready, 1'b1);
        check("fifo_empty", dut.count_s, 0);
        nack_at = -1;
    endtask

    task automatic run(input logic [7:0] addr, input int n, input int base, input int nack_k);
        send_burst(addr, n, base, nack_k);
        finish_burst(nack_k);
    endtask

    // Reset asserted while bytes are being written
    task automatic reset_in_data();
        int t;
        send_burst(8'($urandom), 4, -1, -1);
        t = 0;
        do begin
            @(negedge clk);
            #2;
            t++;
        end while (!(cap_q.size() == 2 && !pulse && en == EN_WR) && t < 2000);
        check("reach_data", (t < 2000), 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_en", en, EN_NONE);
        check("rst_busy", busy, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_fifo", dut.count_s, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready_rise", cmd_ready, 1'b1);
        check("rst_busy_after", busy, 1'b0);
        cap_q.delete();
        nack_at = -1;
    endtask

    initial begin
        int n;
        int nk;
        #1 rst_n = 1'b0;
        #2;
        check("reset_en", en, EN_NONE);
        check("reset_data", data, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_ready", cmd_ready, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", cmd_ready, 1'b1);

        run(8'h00, 1, 8'h96, -1);
        run(8'h00, DEPTH, 8'h96, -1);
        run(8'hFF, 2, -1, -1);
        run(8'h10, 3, -1, 0);
        run(8'h20, 2, -1, -1);

        for (int k = 0; k < 12; k++) begin
            n  = $urandom_range(1, DEPTH);
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, writes_for(n) - 1)) : -1;
            run(8'($urandom), n, -1, nk);
        end

        reset_in_data();
        run(8'($urandom), 5, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
